// File: rtl/vsfx_pkg.sv
// Shared constants for the vector fixed-point issue controller: opcodes,
// FSM state encoding, CR6 bit positions and small decode helpers.
package vsfx_pkg;

  localparam logic [7:0] OP_ADDSWS   = 8'h70;  // add saturating signed word
  localparam logic [7:0] OP_SUBUBM   = 8'h80;  // subtract modulo byte
  localparam logic [7:0] OP_CMPEQH   = 8'h0B;  // compare equal halfword
  localparam logic [7:0] OP_CMPEQH_R = 8'h8B;  // compare equal halfword, record CR6
  localparam logic [7:0] OP_AVGSH    = 8'hA9;  // average halfword
  localparam logic [7:0] OP_SLB      = 8'h22;  // shift left byte
  localparam logic [7:0] OP_NONE     = 8'h00;  // unit treats this as a hold

  localparam int unsigned CR6_ALL_ONES = 3;
  localparam int unsigned CR6_ALL_ZERO = 1;

  // Last watchdog count value; the controller waits at most four cycles.
  localparam logic [1:0] WD_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } vsfx_state_e;

  function automatic logic op_legal(input logic [7:0] op);
    logic ok;
    case (op)
      OP_ADDSWS, OP_SUBUBM, OP_CMPEQH, OP_CMPEQH_R, OP_AVGSH, OP_SLB: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] cr6_calc(input logic [127:0] vrt);
    logic [3:0] cr;
    cr = 4'b0000;
    cr[CR6_ALL_ONES] = &vrt;
    cr[CR6_ALL_ZERO] = ~|vrt;
    return cr;
  endfunction

endpackage

// File: rtl/vsfx_rr_arb.sv
// Two-way round-robin arbiter. The pointer names the requester that has
// priority; it moves past whichever requester is granted.
module vsfx_rr_arb
  import vsfx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic ptr_r;

  // Grant the pointed-to requester first, otherwise the other one.
  always_comb begin
    gnt = 2'b00;
    if (ptr_r == 1'b0) begin
      if (req[0]) gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
      else gnt = 2'b00;
    end else begin
      if (req[1]) gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
      else gnt = 2'b00;
    end
  end

  // Advance the pointer past the granted requester when a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (take && (gnt != 2'b00)) begin
      ptr_r <= gnt[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/vsfx_issue_ctrl.sv
// Issue controller in front of the vector fixed-point unit: arbitrates two
// requesters, issues one op at a time, waits for the result (with a
// watchdog), computes CR6 and hands the result back over a writeback
// handshake. Optional VSCR[SAT] sticky bit under VSFX_SAT_STICKY_EN.
module vsfx_issue_ctrl
  import vsfx_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [15:0]        req_ins,
  input  logic [255:0]       req_vra,
  input  logic [255:0]       req_vrb,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               fx_en,
  output logic [7:0]         fx_ins,
  output logic [127:0]       fx_vra,
  output logic [127:0]       fx_vrb,
  input  logic               fx_vrt_en,
  input  logic [127:0]       fx_vrt,
  input  logic               fx_sat,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic               wb_src,
  output logic [TAG_W-1:0]   wb_tag,
  output logic [127:0]       wb_vrt,
  output logic [3:0]         wb_cr6,
  output logic               wb_cr6_we,
  output logic               wb_err
`ifdef VSFX_SAT_STICKY_EN
  ,
  output logic               sat_sticky,
  input  logic               sat_clr
`endif
);

  vsfx_state_e        state_r, state_s;
  logic [1:0]         gnt_s;
  logic [1:0]         ready_s;
  logic               take_s;
  logic [7:0]         sel_ins_s;
  logic [127:0]       sel_vra_s, sel_vrb_s;
  logic [TAG_W-1:0]   sel_tag_s;
  logic [7:0]         ins_r;
  logic [127:0]       vra_r, vrb_r;
  logic [1:0]         wd_r;
  logic               fx_en_r;
  logic [7:0]         fx_ins_r;
  logic               wb_valid_r, wb_src_r, wb_cr6_we_r, wb_err_r;
  logic [TAG_W-1:0]   wb_tag_r;
  logic [127:0]       wb_vrt_r;
  logic [3:0]         wb_cr6_r;

  assign take_s = (state_r == ST_IDLE);

  vsfx_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .take  (take_s),
    .gnt   (gnt_s)
  );

  // Select the granted requester's opcode, operands and tag.
  always_comb begin
    sel_ins_s = req_ins[7:0];
    sel_vra_s = req_vra[127:0];
    sel_vrb_s = req_vrb[127:0];
    sel_tag_s = req_tag[TAG_W-1:0];
    if (gnt_s[1]) begin
      sel_ins_s = req_ins[15:8];
      sel_vra_s = req_vra[255:128];
      sel_vrb_s = req_vrb[255:128];
      sel_tag_s = req_tag[2*TAG_W-1:TAG_W];
    end else begin
      sel_ins_s = req_ins[7:0];
    end
  end

  // Accept strobe only in IDLE and never while reset is asserted.
  always_comb begin
    ready_s = 2'b00;
    if ((state_r == ST_IDLE) && rst_n) ready_s = gnt_s;
    else ready_s = 2'b00;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          if (op_legal(sel_ins_s)) state_s = ST_ISSUE;
          else state_s = ST_WB;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (fx_vrt_en || (wd_r == WD_LAST)) state_s = ST_WB;
        else state_s = ST_WAIT;
      end
      ST_WB: begin
        if (wb_ready) state_s = ST_IDLE;
        else state_s = ST_WB;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered writeback-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wb_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wb_valid_r <= (state_s == ST_WB);
    end
  end

  // Capture on grant, issue for one cycle, collect the result or time out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_r       <= OP_NONE;
      vra_r       <= 128'd0;
      vrb_r       <= 128'd0;
      wd_r        <= 2'd0;
      fx_en_r     <= 1'b0;
      fx_ins_r    <= OP_NONE;
      wb_src_r    <= 1'b0;
      wb_tag_r    <= '0;
      wb_vrt_r    <= 128'd0;
      wb_cr6_r    <= 4'b0000;
      wb_cr6_we_r <= 1'b0;
      wb_err_r    <= 1'b0;
    end else begin
      fx_en_r  <= 1'b0;
      fx_ins_r <= OP_NONE;
      case (state_r)
        ST_IDLE: begin
          wd_r <= 2'd0;
          if (gnt_s != 2'b00) begin
            ins_r       <= sel_ins_s;
            vra_r       <= sel_vra_s;
            vrb_r       <= sel_vrb_s;
            wb_src_r    <= gnt_s[1];
            wb_tag_r    <= sel_tag_s;
            wb_vrt_r    <= 128'd0;
            wb_cr6_r    <= 4'b0000;
            wb_cr6_we_r <= 1'b0;
            wb_err_r    <= ~op_legal(sel_ins_s);
            if (op_legal(sel_ins_s)) begin
              fx_en_r  <= 1'b1;
              fx_ins_r <= sel_ins_s;
            end
          end
        end
        ST_ISSUE: wd_r <= 2'd0;
        ST_WAIT: begin
          wd_r <= wd_r + 2'd1;
          if (fx_vrt_en) begin
            wb_vrt_r <= fx_vrt;
            wb_err_r <= 1'b0;
            if (ins_r == OP_CMPEQH_R) begin
              wb_cr6_r    <= cr6_calc(fx_vrt);
              wb_cr6_we_r <= 1'b1;
            end
          end else if (wd_r == WD_LAST) begin
            wb_err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VSFX_SAT_STICKY_EN
  logic sat_r;

  // Sticky saturation: a sampled set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && fx_vrt_en && (ins_r == OP_ADDSWS) && fx_sat) begin
      sat_r <= 1'b1;
    end else if (sat_clr) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= sat_r;
    end
  end

  assign sat_sticky = sat_r;
`else
  logic fx_sat_unused_s;
  assign fx_sat_unused_s = fx_sat;
`endif

  assign req_ready = ready_s;
  assign fx_en     = fx_en_r;
  assign fx_ins    = fx_ins_r;
  assign fx_vra    = vra_r;
  assign fx_vrb    = vrb_r;
  assign wb_valid  = wb_valid_r;
  assign wb_src    = wb_src_r;
  assign wb_tag    = wb_tag_r;
  assign wb_vrt    = wb_vrt_r;
  assign wb_cr6    = wb_cr6_r;
  assign wb_cr6_we = wb_cr6_we_r;
  assign wb_err    = wb_err_r;

endmodule

// File: tb/tb_vsfx_issue_ctrl.sv
// Self-checking bench for vsfx_issue_ctrl with a behavioural stand-in for
// the fixed-point unit (one-cycle latency). Sticky-SAT checks are compiled
// only when VSFX_SAT_STICKY_EN is defined.
module tb_vsfx_issue_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [15:0]  req_ins;
  logic [255:0] req_vra, req_vrb;
  logic [7:0]   req_tag;
  logic         fx_en;
  logic [7:0]   fx_ins;
  logic [127:0] fx_vra, fx_vrb;
  logic         fx_vrt_en;
  logic [127:0] fx_vrt;
  logic         fx_sat;
  logic         wb_valid, wb_ready, wb_src;
  logic [3:0]   wb_tag;
  logic [127:0] wb_vrt;
  logic [3:0]   wb_cr6;
  logic         wb_cr6_we, wb_err;
  logic         sat_clr;
`ifdef VSFX_SAT_STICKY_EN
  logic         sat_sticky;
`endif

  int  checks = 0;
  int  failures = 0;
  int  rr_ptr = 0;
  bit  model_sat = 1'b0;
  bit  fx_mute = 1'b0;
  logic [7:0] legal_ops [6] = '{8'h70, 8'h80, 8'h0B, 8'h8B, 8'hA9, 8'h22};

  vsfx_issue_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ins(req_ins),
    .req_vra(req_vra), .req_vrb(req_vrb), .req_tag(req_tag),
    .fx_en(fx_en), .fx_ins(fx_ins), .fx_vra(fx_vra), .fx_vrb(fx_vrb),
    .fx_vrt_en(fx_vrt_en), .fx_vrt(fx_vrt), .fx_sat(fx_sat),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_src(wb_src), .wb_tag(wb_tag),
    .wb_vrt(wb_vrt), .wb_cr6(wb_cr6), .wb_cr6_we(wb_cr6_we), .wb_err(wb_err)
`ifdef VSFX_SAT_STICKY_EN
    , .sat_sticky(sat_sticky), .sat_clr(sat_clr)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [7:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Architectural semantics of each opcode, lane by lane.
  function automatic void ref_exec(input logic [7:0] op, input logic [127:0] a, input logic [127:0] b,
                                   output logic [127:0] r, output bit sat);
    r = 128'd0;
    sat = 1'b0;
    case (op)
      8'h70: for (int i = 0; i < 4; i++) begin
        longint s;
        s = longint'($signed(a[i*32 +: 32])) + longint'($signed(b[i*32 +: 32]));
        if (s > 64'sd2147483647) begin r[i*32 +: 32] = 32'h7FFF_FFFF; sat = 1'b1; end
        else if (s < -64'sd2147483648) begin r[i*32 +: 32] = 32'h8000_0000; sat = 1'b1; end
        else r[i*32 +: 32] = s[31:0];
      end
      8'h80: for (int i = 0; i < 16; i++) r[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
      8'h0B, 8'h8B: for (int i = 0; i < 8; i++)
        r[i*16 +: 16] = (a[i*16 +: 16] == b[i*16 +: 16]) ? 16'hFFFF : 16'h0000;
      8'hA9: for (int i = 0; i < 8; i++) begin
        int t;
        t = (int'(a[i*16 +: 16]) + int'(b[i*16 +: 16]) + 1) >> 1;
        r[i*16 +: 16] = t[15:0];
      end
      8'h22: for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'(a[i*8 +: 8] << b[i*8 +: 3]);
      default: r = 128'd0;
    endcase
  endfunction

  // Stand-in fixed-point unit: result registered one cycle after fx_en.
  always @(posedge clk or negedge rst_n) begin
    logic [127:0] r;
    bit s;
    if (!rst_n) begin
      fx_vrt_en <= 1'b0; fx_vrt <= 128'd0; fx_sat <= 1'b0;
    end else if (fx_en && !fx_mute) begin
      ref_exec(fx_ins, fx_vra, fx_vrb, r, s);
      fx_vrt_en <= 1'b1;
      fx_vrt    <= r;
      fx_sat    <= (fx_ins == 8'h70) ? s : 1'($urandom);
    end else begin
      fx_vrt_en <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from an IDLE start: grant, issue, result, writeback.
  task automatic do_op(input logic [1:0] mask, input logic [7:0] op, input logic [127:0] a,
                       input logic [127:0] b, input logic [3:0] tag, input int hold,
                       input bit mute, input bit clr_wait);
    int idx, n, lat;
    bit legal, fx_seen, sat_hit, ewe;
    logic [127:0] ev;
    logic [3:0] ecr;
    legal = is_legal(op);
    idx = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : rr_ptr;
    ev = 128'd0; sat_hit = 1'b0;
    if (legal && !mute) ref_exec(op, a, b, ev, sat_hit);
    if (op != 8'h70) sat_hit = 1'b0;
    lat = !legal ? 1 : (mute ? 6 : 3);
    ewe = legal && !mute && (op == 8'h8B);
    ecr = ewe ? {ev == {128{1'b1}}, 1'b0, ev == 128'd0, 1'b0} : 4'b0000;

    @(posedge clk); #1;
    fx_mute = mute;
    req_valid = mask;
    if (idx == 0) begin
      req_ins = {8'($urandom), op}; req_vra = {rnd128(), a}; req_vrb = {rnd128(), b};
      req_tag = {4'($urandom), tag};
    end else begin
      req_ins = {op, 8'($urandom)}; req_vra = {a, rnd128()}; req_vrb = {b, rnd128()};
      req_tag = {tag, 4'($urandom)};
    end
    @(negedge clk);
    chk("grant", req_ready, 128'(2'b01 << idx));
    chk("no_wb_at_grant", wb_valid, 0);
    rr_ptr = 1 - idx;

    n = 0; fx_seen = 1'b0;
    while (wb_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      req_valid = 2'b00;
      n++;
      sat_clr = clr_wait && (n == 2);
      @(negedge clk);
      if (fx_en === 1'b1) begin
        fx_seen = 1'b1;
        chk("fx_en_cycle", n, 1);
        chk("fx_ins", fx_ins, op);
        chk("fx_vra", fx_vra, a);
        chk("fx_vrb", fx_vrb, b);
      end else begin
        chk("fx_ins_idle", fx_ins, 0);
      end
      chk("ready_busy", req_ready, 0);
    end
    sat_clr = 1'b0;
    chk("wb_latency", n, lat);
    chk("fx_en_seen", fx_seen, legal);
    if (legal && !mute && sat_hit) model_sat = 1'b1;
    else if (clr_wait && legal) model_sat = 1'b0;

    for (int k = 0; k <= hold + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == hold + 1) wb_ready = 1'b1;
        @(negedge clk);
      end
      chk("wb_valid", wb_valid, 1);
      chk("ready_in_wb", req_ready, 0);
      chk("wb_src", wb_src, idx);
      chk("wb_tag", wb_tag, tag);
      chk("wb_err", wb_err, !legal || mute);
      if (!mute) chk("wb_vrt", wb_vrt, ev);
      chk("wb_cr6", wb_cr6, ecr);
      chk("wb_cr6_we", wb_cr6_we, ewe);
`ifdef VSFX_SAT_STICKY_EN
      chk("sat_sticky", sat_sticky, model_sat);
`endif
    end
    @(posedge clk); #1;
    wb_ready = 1'b0;
    fx_mute = 1'b0;
  endtask

  initial begin
    logic [127:0] a, b;
    logic [7:0] op;
    int gcount;
    rst_n = 1'b0; req_valid = 2'b11; req_ins = 16'h7070; req_vra = 256'd0; req_vrb = 256'd0;
    req_tag = 8'h00; wb_ready = 1'b0; sat_clr = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fx_en", fx_en, 0);
    chk("rst_fx_ins", fx_ins, 0);
    chk("rst_wb_fields", {wb_src, wb_tag, wb_cr6, wb_cr6_we, wb_err}, 0);
    chk("rst_wb_vrt", wb_vrt, 0);
`ifdef VSFX_SAT_STICKY_EN
    chk("rst_sat", sat_sticky, 0);
`endif
    repeat (2) @(posedge clk);
    #1; req_valid = 2'b00; rst_n = 1'b1;

    // Saturating add on requester 0.
    a = rnd128(); b = rnd128();
    a[31:0] = 32'h7FFF_FFFF; b[31:0] = 32'h0000_0001;
    do_op(2'b01, 8'h70, a, b, 4'h3, 0, 1'b0, 1'b0);
    // Recorded compare with equal operands on requester 1, writeback stalled.
    a = {8{16'h1234}};
    do_op(2'b10, 8'h8B, a, a, 4'hA, 5, 1'b0, 1'b0);
    // Set and clear in the same cycle: set wins.
    do_op(2'b01, 8'h70, {4{32'h7000_0000}}, {4{32'h7000_0000}}, 4'h5, 0, 1'b0, 1'b1);
    // Clear with no set.
    do_op(2'b10, 8'h80, rnd128(), rnd128(), 4'h6, 1, 1'b0, 1'b1);
    // Illegal opcode.
    do_op(2'b01, 8'h55, rnd128(), rnd128(), 4'h7, 1, 1'b0, 1'b0);
    // Unit never answers: watchdog.
    do_op(2'b10, 8'h80, rnd128(), rnd128(), 4'h9, 0, 1'b1, 1'b0);

    // Both requesters held with writeback always ready.
    @(posedge clk); #1;
    req_valid = 2'b11; wb_ready = 1'b1; req_ins = 16'h8080;
    req_vra = {rnd128(), rnd128()}; req_vrb = {rnd128(), rnd128()};
    gcount = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("ready_wb_excl", wb_valid && (req_ready != 2'b00), 0);
      if (req_ready != 2'b00) begin
        chk("rr_spacing", c, 4 * gcount);
        chk("rr_order", req_ready, 128'(2'b01 << rr_ptr));
        rr_ptr = 1 - rr_ptr;
        gcount++;
      end
      @(posedge clk); #1;
    end
    chk("rr_grants", gcount, 4);
    req_valid = 2'b00; wb_ready = 1'b0;

    // Random traffic.
    for (int t = 0; t < 14; t++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      op = legal_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) begin
        op = 8'($urandom);
        if (is_legal(op)) op = 8'h55;
      end
      a = rnd128();
      b = ($urandom_range(0, 2) == 0) ? a : rnd128();
      do_op(m, op, a, b, 4'($urandom), $urandom_range(0, 2), 1'b0, 1'($urandom));
    end

    // Reset while waiting for a result.
    do_op(2'b01, 8'h80, rnd128(), rnd128(), 4'h1, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    fx_mute = 1'b1; req_valid = 2'b01; req_ins = 16'h0070;
    @(posedge clk); #1; req_valid = 2'b00;
    @(posedge clk); #1;
    req_valid = 2'b11; rst_n = 1'b0;
    rr_ptr = 0; model_sat = 1'b0;
    #1;
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_fx_en", fx_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b00; fx_mute = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_wb", wb_valid, 0);
    end
    do_op(2'b11, 8'hA9, rnd128(), rnd128(), 4'hC, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vsfx_issue_ctrl.md
VSFX_ISSUE_CTRL -- requirements
Module: vsfx_issue_ctrl

Interface
REQ-001 Parameter TAG_W, default 4, width of the requester tag returned with each result.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester (bit i = requester i) operation request.
REQ-005 req_ready  output  2  per-requester grant/accept strobe.
REQ-006 req_ins  input  16  two 8-bit opcodes {req1, req0}, packed ins field as consumed by the vector fixed-point unit.
REQ-007 req_vra, req_vrb  input  256 each  two 128-bit source operands per operand port {req1, req0}.
REQ-008 req_tag  input  2*TAG_W  per-requester tag.
REQ-009 fx_en, fx_ins, fx_vra, fx_vrb  output  1/8/128/128  drive to the vector fixed-point unit.
REQ-010 fx_vrt_en, fx_vrt, fx_sat  input  1/128/1  registered results from the unit.
REQ-011 wb_valid  output  1 / wb_ready  input  1  writeback handshake.
REQ-012 wb_src  output  1 / wb_tag  output  TAG_W / wb_vrt  output  128  result source, tag, data.
REQ-013 wb_cr6  output  4 / wb_cr6_we  output  1 / wb_err  output  1  CR6 value, CR6 write enable, illegal-op flag.
REQ-014 sat_sticky  output  1 / sat_clr  input  1  VSCR[SAT] sticky bit and clear (present only with VSFX_SAT_STICKY_EN).

Function
REQ-015 Legal opcodes SHALL be 0x70 add-sat-word, 0x80 sub-byte, 0x0B cmp-eq-half, 0x8B cmp-eq-half record, 0xA9 avg-half, 0x22 shift-left-byte; all others illegal.
REQ-016 FSM SHALL have states IDLE, ISSUE, WAIT, WB.
REQ-017 IDLE: if any req_valid, round-robin arbiter grants one; req_ready[grant]=1 for that cycle only; opcode, operands, tag, source captured; next ISSUE (legal) or WB with wb_err=1, wb_vrt=0 (illegal).
REQ-018 req_ready SHALL be 0 in ISSUE, WAIT, WB.
REQ-019 Round-robin: pointer advances past granted requester on each grant; with both valid, grants alternate.
REQ-020 ISSUE: fx_en=1, fx_ins/fx_vra/fx_vrb = captured values for exactly one cycle; next WAIT.
REQ-021 Outside ISSUE, fx_en=0 and fx_ins=0x00 (illegal opcode, unit holds its output).
REQ-022 WAIT: on fx_vrt_en=1 capture fx_vrt into wb_vrt, next WB; watchdog counter of 4 cycles in WAIT, on expiry go WB with wb_err=1.
REQ-023 Latency: grant edge to wb_valid=1 is exactly 3 cycles for a legal op with unit latency 1.
REQ-024 CR6 SHALL be computed by the controller from captured result: wb_cr6={all_ones,0,all_zero,0}; wb_cr6_we=1 only for 0x8B, else wb_cr6=0.
REQ-025 WB: wb_valid=1, all wb_* held stable until wb_ready=1; handshake cycle returns to IDLE.
REQ-026 wb_valid and req_ready SHALL never both be 1 in the same cycle.
REQ-027 fx_sat SHALL be sampled only with fx_vrt_en for opcode 0x70; ignored otherwise.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, RR pointer to requester 0, wb_valid=0, req_ready=0, fx_en=0, fx_ins=0, all wb_* and sat_sticky=0, watchdog=0.
REQ-029 Reset mid-operation SHALL discard the in-flight op with no writeback.

Configuration
REQ-030 With VSFX_SAT_STICKY_EN defined: sat_sticky sets on sampled fx_sat=1, clears on sat_clr=1; set wins if both in same cycle; sat_sticky and sat_clr exist as ports.
REQ-031 Without VSFX_SAT_STICKY_EN: ports sat_sticky and sat_clr absent; fx_sat unused.

Structure
REQ-032 Package vsfx_pkg SHALL hold the opcode constants, FSM state encoding, CR6 bit positions.
REQ-033 Sub-module vsfx_rr_arb (2-way round-robin arbiter with pointer register) SHALL perform grant selection.
REQ-034 Controller SHALL NOT instantiate the fixed-point unit; parent connects fx_* ports.

Verification
REQ-035 req0 op 0x70, vra lane0=0x7FFFFFFF, vrb lane0=0x00000001 -> wb_vrt lane0=0x7FFFFFFF, wb_valid 3 cycles after grant, sat_sticky=1.
REQ-036 req1 op 0x8B, vra=vrb=0x1234...(equal) -> wb_vrt all ones, wb_cr6=4'b1000, wb_cr6_we=1, wb_src=1.
REQ-037 Both req_valid held 1, wb_ready=1 -> grants 0,1,0,1 with one grant per 4 cycles.
REQ-038 req0 op 0x55 -> fx_en never asserted, wb_err=1, wb_vrt=0, wb_valid 1 cycle after grant.
REQ-039 wb_ready=0 for 5 cycles in WB -> wb_* stable, req_ready=2'b00; sat_clr with simultaneous set -> sat_sticky=1.
REQ-040 rst_n=0 during WAIT -> wb_valid stays 0, next grant to requester 0 with both valid.
